// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: command encodings, scan codes and the scan-code decoder shared by the key queue.
package key_cmd_pkg;
  localparam int NUM_CMDS = 7;
  localparam logic [2:0] CMD_UP = 3'd0;
  localparam logic [2:0] CMD_DW = 3'd1;
  localparam logic [2:0] CMD_LF = 3'd2;
  localparam logic [2:0] CMD_RT = 3'd3;
  localparam logic [2:0] CMD_PS = 3'd4;
  localparam logic [2:0] CMD_HF = 3'd5;
  localparam logic [2:0] CMD_VF = 3'd6;
  localparam logic [7:0] SC_UP = 8'h1D;
  localparam logic [7:0] SC_DW = 8'h1B;
  localparam logic [7:0] SC_LF = 8'h1C;
  localparam logic [7:0] SC_RT = 8'h23;
  localparam logic [7:0] SC_PS = 8'h4D;
  localparam logic [7:0] SC_HF = 8'h33;
  localparam logic [7:0] SC_VF = 8'h2A;
  // Returns {hit, cmd}; extended codes never hit.
  function automatic logic [3:0] decode_key(input logic [8:0] code);
    logic [7:0] s;
    s = code[7:0];
    return code[8]   ? 4'b0 :
           s == SC_UP ? {1'b1, CMD_UP} :
           s == SC_DW ? {1'b1, CMD_DW} :
           s == SC_LF ? {1'b1, CMD_LF} :
           s == SC_RT ? {1'b1, CMD_RT} :
           s == SC_PS ? {1'b1, CMD_PS} :
           s == SC_HF ? {1'b1, CMD_HF} :
           s == SC_VF ? {1'b1, CMD_VF} : 4'b0;
  endfunction
endpackage

// File: rtl/key_cmd_queue_fifo.sv
// cmd_fifo: generic synchronous FIFO with flush; a push into a full FIFO is accepted only alongside a pop.
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/key_cmd_queue.sv
// key_cmd_queue: maps scan codes to display commands, suppresses typematic repeats
// with a held bitmap, and queues one-shot commands for the address generator.
module key_cmd_queue
  import key_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [8:0] last_change,
  input  logic       key_make,
  input  logic       clear,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic       overflow
);
  logic [NUM_CMDS-1:0] held;
  logic [3:0] dec;
  logic [2:0] kc;
  logic hit, push_req, push, pop, full, empty;
  logic [$clog2(DEPTH):0] fifo_count;
  assign dec       = decode_key(last_change);
  assign kc        = dec[2:0];
  assign hit       = key_valid && dec[3];
  assign push_req  = hit && key_make && !held[kc];
  assign push      = push_req && !clear;
  assign pop       = cmd_ready && !empty && !clear;
  assign cmd_valid = |fifo_count;
  cmd_fifo #(.WIDTH(3), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .clr(clear), .push(push), .pop(pop), .din(kc),
    .full(full), .empty(empty), .head(cmd), .count(fifo_count)
  );
  // Held survives clear so a still-pressed key is not re-queued by its repeats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) held <= '0;
    else if (hit) held[kc] <= key_make;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (push_req && full && !pop) overflow <= 1'b1;
  end
endmodule
